// File: rtl/ifq_pkg.sv
// ifq_pkg: types and constants shared by the instruction fetch queue.
//   ifq_entry_t  - one queue slot: PC, fetched instruction word, slot state
//   ent_state_e  - FREE / ALLOC (PC stored, awaiting data) / FILLED
//   IFQ_NOP      - instruction presented to decode when nothing is valid
//   IFQ_DEPTH_DEFAULT - default number of queue slots
// The PC field is sized for the widest supported address (IFQ_PC_MAX_W);
// narrower configurations use the low Width bits only.
package ifq_pkg;

    localparam int unsigned IFQ_DEPTH_DEFAULT = 2;
    localparam int unsigned IFQ_PC_MAX_W      = 64;
    localparam logic [31:0] IFQ_NOP           = 32'h0000_0013;

    typedef enum logic [1:0] {
        ENT_FREE   = 2'd0,
        ENT_ALLOC  = 2'd1,
        ENT_FILLED = 2'd2
    } ent_state_e;

    typedef struct packed {
        logic [IFQ_PC_MAX_W-1:0] pc;
        logic [31:0]             instr;
        ent_state_e              state;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: slot storage and head/fill/tail pointers for the fetch queue.
//   clk, reset        - clock, asynchronous active-low reset
//   alloc_i/alloc_pc_i - claim the tail slot and record its PC
//   fill_i/fill_data_i - write the instruction into the oldest ALLOC slot
//   pop_i             - release the head slot
//   flush_i           - free every slot and rewind all pointers (wins)
//   count_o           - occupied slots (ALLOC + FILLED)
//   pend_o            - ALLOC slots still waiting for their instruction
//   head_*_o          - head slot contents
// Callers guarantee alloc only with a free tail, fill only with pend_o != 0
// and pop only when the head is FILLED, so the three never touch the same slot.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned DEPTH = IFQ_DEPTH_DEFAULT,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_i,
    input  logic [Width-1:0] alloc_pc_i,
    input  logic             fill_i,
    input  logic [31:0]      fill_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CntW-1:0]  count_o,
    output logic [CntW-1:0]  pend_o,
    output logic             head_filled_o,
    output logic [Width-1:0] head_pc_o,
    output logic [31:0]      head_instr_o
);

    ifq_entry_t      ent_q [DEPTH];
    ifq_entry_t      ent_d [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] fill_q, fill_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] pend_q, pend_d;

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        fill_d  = fill_q;
        tail_d  = tail_q;
        count_d = count_q;
        pend_d  = pend_q;
        if (flush_i) begin
            // Stored PCs are left in place; only slot state is discarded.
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_d[i].state = ENT_FREE;
            end
            head_d  = '0;
            fill_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end else begin
            if (alloc_i) begin
                ent_d[tail_q].pc             = '0;
                ent_d[tail_q].pc[Width-1:0]  = alloc_pc_i;
                ent_d[tail_q].state          = ENT_ALLOC;
                tail_d                       = tail_q + 1'b1;
            end
            if (fill_i) begin
                ent_d[fill_q].instr = fill_data_i;
                ent_d[fill_q].state = ENT_FILLED;
                fill_d              = fill_q + 1'b1;
            end
            if (pop_i) begin
                ent_d[head_q].state = ENT_FREE;
                head_d              = head_q + 1'b1;
            end
            count_d = count_q + CntW'(alloc_i) - CntW'(pop_i);
            pend_d  = pend_q + CntW'(alloc_i) - CntW'(fill_i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            fill_q  <= fill_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    assign count_o       = count_q;
    assign pend_o        = pend_q;
    assign head_filled_o = (ent_q[head_q].state == ENT_FILLED);
    assign head_pc_o     = ent_q[head_q].pc[Width-1:0];
    assign head_instr_o  = ent_q[head_q].instr;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decouples instruction-memory fetch from decode.
//   clk, reset          - clock, asynchronous active-low reset
//   pc_i / pc_en_o      - current PC in; advance enable out (= request handshake)
//   imem_req_*          - request channel (address = pc_i)
//   imem_rsp_*          - in-order response channel, latency >= 1
//   flush_i             - redirect: drop queued and in-flight fetches
//   dec_*               - valid/ready channel toward decode
//   stall_cnt_o         - decode-starved cycle counter, only when the
//                         IFQ_STALL_CNT_EN macro is defined
// Requests are gated only on registered occupancy, so a decode pop never
// opens a slot for a request in the same cycle (no ready->valid path).
// Responses that belong to fetches killed by a flush are counted in the
// discard counter and dropped as they return.
module if_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned DEPTH = IFQ_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] pc_i,
    output logic             pc_en_o,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [Width-1:0] imem_req_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [31:0]      imem_rsp_data_i,
    input  logic             flush_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [31:0]      dec_instr_o,
    output logic [Width-1:0] dec_pc_o
`ifdef IFQ_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [CntW-1:0]  count;
    logic [CntW-1:0]  pend;
    logic             head_filled;
    logic [Width-1:0] head_pc;
    logic [31:0]      head_instr;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_fill;
    logic             pop;
    logic [CntW-1:0]  disc_q, disc_d;
    logic [31:0]      disc_sum;

    // reset term keeps the request idle while the block is held in reset
    assign imem_req_valid_o = reset && !flush_i && (count < CntW'(DEPTH));
    assign imem_req_addr_o  = pc_i;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign pc_en_o          = req_fire;

    assign rsp_drop = imem_rsp_valid_i && (disc_q != '0);
    assign rsp_fill = imem_rsp_valid_i && (disc_q == '0) && (pend != '0);

    assign dec_valid_o = head_filled;
    assign dec_instr_o = head_filled ? head_instr : IFQ_NOP;
    assign dec_pc_o    = head_pc;
    assign pop         = head_filled && dec_ready_i;

    ifq_fifo #(
        .Width (Width),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .alloc_i       (req_fire),
        .alloc_pc_i    (pc_i),
        .fill_i        (rsp_fill),
        .fill_data_i   (imem_rsp_data_i),
        .pop_i         (pop),
        .flush_i       (flush_i),
        .count_o       (count),
        .pend_o        (pend),
        .head_filled_o (head_filled),
        .head_pc_o     (head_pc),
        .head_instr_o  (head_instr)
    );

    // On flush every unfilled slot still has a response coming back. A
    // response landing in the flush cycle itself has already been consumed
    // (dropped or matched to a dying slot), and any drain still in progress
    // carries over. Saturate at DEPTH so the counter width always holds.
    always_comb begin
        disc_d   = disc_q;
        disc_sum = 32'(disc_q) + 32'(pend) - 32'(rsp_drop) - 32'(rsp_fill);
        if (flush_i) begin
            disc_d = (disc_sum > DEPTH) ? CntW'(DEPTH) : CntW'(disc_sum);
        end else if (rsp_drop) begin
            disc_d = disc_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disc_q <= '0;
        end else begin
            disc_q <= disc_d;
        end
    end

`ifdef IFQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (dec_ready_i && !dec_valid_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
